// File: rtl/tag_bank_ctrl_if.sv
// Request/response bundle between the fetch path and tag_bank_ctrl: lookups, fills, flush.
interface tag_bank_ctrl_if #(
   parameter int LINES = 512,
   parameter int TAG_W = 20
);
   localparam int LW = $clog2(LINES);

   logic             lookup_req;
   logic [LW-1:0]    lookup_line;
   logic [TAG_W-1:0] lookup_tag;
   logic             lookup_ready;
   logic             hit_valid;
   logic             hit;
   logic             fill_req;
   logic [LW-1:0]    fill_line;
   logic [TAG_W-1:0] fill_tag;
   logic             fill_ack;
   logic             flush_req;
   logic             flush_busy;
   logic             parity_err;

   modport master (
      output lookup_req, lookup_line, lookup_tag, fill_req, fill_line, fill_tag, flush_req,
      input  lookup_ready, hit_valid, hit, fill_ack, flush_busy, parity_err
   );

   modport slave (
      input  lookup_req, lookup_line, lookup_tag, fill_req, fill_line, fill_tag, flush_req,
      output lookup_ready, hit_valid, hit, fill_ack, flush_busy, parity_err
   );
endinterface

// File: rtl/tag_bank_ctrl.sv
// Port sequencer for the I-cache dual-port tag bank: lookups on A, fills and invalidate sweeps on B.
// Optional entry parity is enabled by defining TAG_PARITY_EN.
module tag_bank_ctrl #(
   parameter int LINES = 512,
   parameter int TAG_W = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   tag_bank_ctrl_if.slave          bus,
   output logic                    bank_en_a,
   output logic                    bank_wen_a,
   output logic [$clog2(LINES)-1:0] bank_addr_a,
`ifdef TAG_PARITY_EN
   input  logic [TAG_W+1:0]        bank_data_out_a,
   output logic [TAG_W+1:0]        bank_data_in_b,
`else
   input  logic [TAG_W:0]          bank_data_out_a,
   output logic [TAG_W:0]          bank_data_in_b,
`endif
   output logic                    bank_en_b,
   output logic                    bank_wen_b,
   output logic [$clog2(LINES)-1:0] bank_addr_b
);
   localparam int LW = $clog2(LINES);
`ifdef TAG_PARITY_EN
   localparam int ENTRY_W = TAG_W + 2;
`else
   localparam int ENTRY_W = TAG_W + 1;
`endif

   typedef enum logic [1:0] {CLEAR, RUN, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    clear_idx_q;
   logic             pend_q;
   logic [TAG_W-1:0] tag_q;
   logic             sweep;
   logic             hazard;
   logic             accept;
   logic             fill_go;
   logic [ENTRY_W-1:0] fill_entry;
   logic             tag_match;
   logic             perr;

`ifdef TAG_PARITY_EN
   assign fill_entry = {^{1'b1, bus.fill_tag}, 1'b1, bus.fill_tag};
   // A stored word always has even total parity, so any odd XOR is corruption.
   assign perr       = ^bank_data_out_a;
`else
   assign fill_entry = {1'b1, bus.fill_tag};
   assign perr       = 1'b0;
`endif

   assign tag_match = bank_data_out_a[TAG_W] && (bank_data_out_a[TAG_W-1:0] == tag_q);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d        = state_q;
      sweep          = (state_q != RUN);
      hazard         = bus.fill_req && (bus.fill_line == bus.lookup_line);
      accept         = 1'b0;
      fill_go        = 1'b0;
      bank_en_a      = 1'b0;
      bank_wen_a     = 1'b0;
      bank_addr_a    = bus.lookup_line;
      bank_en_b      = 1'b0;
      bank_wen_b     = 1'b0;
      bank_addr_b    = clear_idx_q;
      bank_data_in_b = '0;

      case (state_q)
         CLEAR, FLUSH: begin
            bank_en_b  = 1'b1;
            bank_wen_b = 1'b1;
            if (clear_idx_q == LW'(LINES - 1)) state_d = RUN;
         end
         RUN: begin
            // The fill wins a same-line collision so A never reads a line B is writing.
            accept  = bus.lookup_req && !hazard;
            fill_go = bus.fill_req;
            if (accept) bank_en_a = 1'b1;
            if (fill_go) begin
               bank_en_b      = 1'b1;
               bank_wen_b     = 1'b1;
               bank_addr_b    = bus.fill_line;
               bank_data_in_b = fill_entry;
            end
            if (bus.flush_req) state_d = FLUSH;
         end
         default: state_d = CLEAR;
      endcase
   end

   assign bus.lookup_ready = (state_q == RUN) && !hazard;
   assign bus.fill_ack     = fill_go;
   assign bus.flush_busy   = sweep;
   assign bus.hit_valid    = pend_q;
   assign bus.hit          = pend_q && tag_match && !perr;
   assign bus.parity_err   = pend_q && perr;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q     <= CLEAR;
         clear_idx_q <= '0;
         pend_q      <= 1'b0;
         tag_q       <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == RUN)  clear_idx_q <= '0;
         else if (sweep)      clear_idx_q <= clear_idx_q + 1'b1;
         pend_q <= accept;
         if (accept) tag_q <= bus.lookup_tag;
      end
   end
endmodule

// File: tb/tb_tag_bank_ctrl.sv
// Scoreboard bench for tag_bank_ctrl with a behavioural tag model and a simulated dual-port bank.
module tb_tag_bank_ctrl;
   localparam int LINES = 16;
   localparam int TAG_W = 8;
   localparam int LW    = $clog2(LINES);
`ifdef TAG_PARITY_EN
   localparam int EW = TAG_W + 2;
`else
   localparam int EW = TAG_W + 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tag_bank_ctrl_if #(.LINES(LINES), .TAG_W(TAG_W)) bus ();

   logic          bank_en_a, bank_wen_a, bank_en_b, bank_wen_b;
   logic [LW-1:0] bank_addr_a, bank_addr_b;
   logic [EW-1:0] bank_data_out_a, bank_data_in_b;

   tag_bank_ctrl #(.LINES(LINES), .TAG_W(TAG_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .bank_en_a      (bank_en_a),
      .bank_wen_a     (bank_wen_a),
      .bank_addr_a    (bank_addr_a),
      .bank_data_out_a(bank_data_out_a),
      .bank_data_in_b (bank_data_in_b),
      .bank_en_b      (bank_en_b),
      .bank_wen_b     (bank_wen_b),
      .bank_addr_b    (bank_addr_b)
   );

   // Dual-port bank with synchronous read; the read path can corrupt one line on demand.
   logic [EW-1:0] mem [LINES];
   logic [EW-1:0] rd_q;
   bit            corrupt_en = 0;
   logic [LW-1:0] corrupt_line = '0;
   always @(posedge clk) begin
      if (bank_en_b && bank_wen_b) mem[bank_addr_b] <= bank_data_in_b;
      if (bank_en_a)
         rd_q <= mem[bank_addr_a] ^ ((corrupt_en && bank_addr_a == corrupt_line) ? EW'(1) : EW'(0));
   end
   assign bank_data_out_a = rd_q;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: the architectural content of every line plus the expected sweep progress.
   bit               ref_valid [LINES];
   logic [TAG_W-1:0] ref_tag   [LINES];
   int               sweep_left = 0;

   typedef struct {
      logic hit;
      logic perr;
      int   cyc;
   } exp_t;
   exp_t sb[$];

   function automatic logic [EW-1:0] entry_of(input logic [TAG_W-1:0] tag);
      logic par;
      par = (($countones(tag) + 1) % 2) == 1;
`ifdef TAG_PARITY_EN
      return {par, 1'b1, tag};
`else
      return {1'b1, tag};
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.hit_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_hit_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("hit_latency", cyc, e.cyc + 1);
               check("hit", bus.hit, e.hit);
               check("parity_err", bus.parity_err, e.perr);
            end
         end else if (bus.hit || bus.parity_err) begin
            check("stray_result", {bus.hit, bus.parity_err}, 0);
         end
         if (bank_en_a)
            check("port_a_hazard",
                  {bank_wen_a, bank_en_b && bank_wen_b && bank_addr_b == bank_addr_a}, 0);
      end
   end

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) begin
         ref_valid[i] = 0;
         ref_tag[i]   = '0;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.lookup_req = 0; bus.fill_req = 0; bus.flush_req = 0;
      repeat (n) @(posedge clk);
      #1;
      check("rst_lookup_ready", bus.lookup_ready, 0);
      check("rst_hit_valid", bus.hit_valid, 0);
      check("rst_hit", bus.hit, 0);
      check("rst_fill_ack", bus.fill_ack, 0);
      check("rst_flush_busy", bus.flush_busy, 1);
      check("rst_parity_err", bus.parity_err, 0);
      rst = 1'b0;
      sb.delete();
      clear_model();
      sweep_left = LINES;
   endtask

   // One clock of stimulus; entered and left just after a rising edge.
   task automatic step(input bit lreq, input logic [LW-1:0] lline, input logic [TAG_W-1:0] ltag,
                       input bit freq, input logic [LW-1:0] fline, input logic [TAG_W-1:0] ftag,
                       input bit flush);
      bit busy, acc, perr;
      bus.lookup_req = lreq; bus.lookup_line = lline; bus.lookup_tag = ltag;
      bus.fill_req = freq;   bus.fill_line = fline;   bus.fill_tag = ftag;
      bus.flush_req = flush;
      @(negedge clk);
      busy = sweep_left > 0;
      acc  = lreq && !busy && !(freq && fline == lline);
      check("flush_busy", bus.flush_busy, busy);
      check("fill_ack", bus.fill_ack, freq && !busy);
      check("lookup_ready", bus.lookup_ready, !busy && !(freq && fline == lline));
      if (busy) begin
         check("sweep_port_b", {bank_en_b, bank_wen_b, 4'(bank_addr_b)}, {2'b11, 4'(LINES - sweep_left)});
         check("sweep_data", bank_data_in_b, 0);
      end else if (freq) begin
         check("fill_port_b", {bank_en_b, bank_wen_b, 4'(bank_addr_b)}, {2'b11, 4'(fline)});
         check("fill_data", bank_data_in_b, entry_of(ftag));
      end
      if (acc) begin
         check("lookup_port_a", {bank_en_a, 4'(bank_addr_a)}, {1'b1, 4'(lline)});
         perr = corrupt_en && lline == corrupt_line;
`ifndef TAG_PARITY_EN
         perr = 0;
`endif
         sb.push_back('{hit: ref_valid[lline] && ref_tag[lline] == ltag && !perr, perr: perr, cyc: cyc});
      end
      if (!busy && freq) begin
         ref_valid[fline] = 1;
         ref_tag[fline]   = ftag;
      end
      if (busy) sweep_left--;
      else if (flush) begin
         sweep_left = LINES;
         clear_model();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, '0, '0, 0, '0, '0, 0);
   endtask

   task automatic lookup(input logic [LW-1:0] l, input logic [TAG_W-1:0] t);
      step(1, l, t, 0, '0, '0, 0);
   endtask

   task automatic fill(input logic [LW-1:0] l, input logic [TAG_W-1:0] t);
      step(0, '0, '0, 1, l, t, 0);
   endtask

   initial begin
      bit pf;
      logic [LW-1:0]    pfl;
      logic [TAG_W-1:0] pft;
      bus.lookup_req = 0; bus.lookup_line = '0; bus.lookup_tag = '0;
      bus.fill_req = 0;   bus.fill_line = '0;   bus.fill_tag = '0;
      bus.flush_req = 0;
      @(posedge clk);
      do_reset(3);
      idle(LINES + 1);

      fill(3, 8'h5A);
      lookup(3, 8'h5A);
      lookup(3, 8'h5B);

      step(1, 7, 8'h11, 1, 7, 8'h11, 0);
      lookup(7, 8'h11);

      fill(1, 8'h21);
      fill(2, 8'h22);
      step(1, 1, 8'h21, 0, '0, '0, 1);
      repeat (LINES) step(0, '0, '0, 1, 5, 8'h55, 0);
      step(0, '0, '0, 1, 5, 8'h55, 0);
      lookup(1, 8'h21);
      lookup(2, 8'h22);
      lookup(5, 8'h55);
      lookup(7, 8'h11);

      step(0, '0, '0, 0, '0, '0, 1);
      idle(9);
      do_reset(1);
      idle(LINES);
      lookup(3, 8'h5A);

`ifdef TAG_PARITY_EN
      fill(4, 8'h33);
      lookup(4, 8'h33);
      corrupt_en = 1; corrupt_line = 4;
      lookup(4, 8'h33);
      lookup(4, 8'h32);
      corrupt_en = 0;
      lookup(4, 8'h33);
`endif

      pf = 0; pfl = '0; pft = '0;
      for (int i = 0; i < 600; i++) begin
         bit busy_before, lreq, fl;
         logic [LW-1:0]    ll;
         logic [TAG_W-1:0] lt;
         if (!pf && $urandom_range(0, 99) < 30) begin
            pf  = 1;
            pfl = LW'($urandom_range(0, LINES - 1));
            pft = TAG_W'($urandom_range(0, 3));
         end
         lreq = $urandom_range(0, 99) < 70;
         ll   = LW'($urandom_range(0, LINES - 1));
         lt   = TAG_W'($urandom_range(0, 3));
         fl   = $urandom_range(0, 149) == 0;
         busy_before = sweep_left > 0;
         step(lreq, ll, lt, pf, pfl, pft, fl);
         if (pf && !busy_before) pf = 0;
      end

      idle(2);
      check("scoreboard_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
